// File: rtl/adder_pair_2bit.sv
// Registered dual-implementation adder: ripple-carry and flat carry-lookahead
// results side by side, plus a registered flag when the two disagree.
module adder_pair_2bit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum_r,
    output logic             co_r,
    output logic [WIDTH-1:0] sum_l,
    output logic             co_l,
    output logic             mismatch
);

    // Lookahead carry k as a flat sum of products of g, p and ci only.
    function automatic logic la_carry(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input logic             c0,
                                      input int               k);
        logic acc;
        logic term;
        acc  = 1'b0;
        term = c0;
        for (int j = 0; j < k; j++) term = term & p[j];
        acc = acc | term;
        for (int j = 0; j < k; j++) begin
            term = g[j];
            for (int m = j + 1; m < k; m++) term = term & p[m];
            acc = acc | term;
        end
        return acc;
    endfunction

    logic [WIDTH:0]   rc;
    logic [WIDTH-1:0] rs;
    logic [WIDTH:0]   lc;
    logic [WIDTH-1:0] lg, lp, ls;

    assign rc[0] = ci;
    assign lc[0] = ci;
    assign lg    = a & b;
    assign lp    = a ^ b;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            adder_pair_fa u_fa (
                .a_i (a[i]),
                .b_i (b[i]),
                .c_i (rc[i]),
                .s_o (rs[i]),
                .c_o (rc[i+1])
            );
            assign lc[i+1] = la_carry(lg, lp, ci, i + 1);
            assign ls[i]   = lp[i] ^ lc[i];
        end
    endgenerate

    logic [WIDTH-1:0] sum_r_q, sum_r_d, sum_l_q, sum_l_d;
    logic             co_r_q, co_r_d, co_l_q, co_l_d, mis_q, mis_d;

    always_comb begin
        sum_r_d = rs;
        co_r_d  = rc[WIDTH];
        sum_l_d = ls;
        co_l_d  = lc[WIDTH];
        mis_d   = ({rc[WIDTH], rs} != {lc[WIDTH], ls});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r_q <= '0;
            co_r_q  <= 1'b0;
            sum_l_q <= '0;
            co_l_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            sum_r_q <= sum_r_d;
            co_r_q  <= co_r_d;
            sum_l_q <= sum_l_d;
            co_l_q  <= co_l_d;
            mis_q   <= mis_d;
        end
    end

    assign sum_r    = sum_r_q;
    assign co_r     = co_r_q;
    assign sum_l    = sum_l_q;
    assign co_l     = co_l_q;
    assign mismatch = mis_q;

endmodule

// One ripple stage.
module adder_pair_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: tb/tb_adder_pair_2bit.sv
// Directed and exhaustive checks of adder_pair_2bit at WIDTH=2.
module tb_adder_pair_2bit;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a, b;
    logic       ci;
    logic [1:0] sum_r, sum_l;
    logic       co_r, co_l, mismatch;
    int         checks   = 0;
    int         failures = 0;

    adder_pair_2bit #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci),
        .sum_r(sum_r), .co_r(co_r), .sum_l(sum_l), .co_l(co_l),
        .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Observation packing: {co_r, sum_r, co_l, sum_l, mismatch}.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1; a = 2'b11; b = 2'b11; ci = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            obs = {co_r, sum_r, co_l, sum_l, mismatch};
            checks++;
            if (obs !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold%0d got=%b want=%b", k, obs, 7'b0);
            end
        end
        rst = 1'b0;
        step();
        obs = {co_r, sum_r, co_l, sum_l, mismatch};
        checks++;
        if (obs !== 7'b111_111_0) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs, 7'b1111110);
        end
    endtask

    task automatic test_directed();
        // {a, b, ci, expected co, expected sum}
        logic [7:0] vec [5];
        logic [6:0] obs, want;
        vec[0] = {2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
        vec[1] = {2'b01, 2'b10, 1'b0, 1'b0, 2'b11};
        vec[2] = {2'b11, 2'b11, 1'b0, 1'b1, 2'b10};
        vec[3] = {2'b11, 2'b00, 1'b1, 1'b1, 2'b00};
        vec[4] = {2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
        for (int k = 0; k < 5; k++) begin
            a = vec[k][7:6]; b = vec[k][5:4]; ci = vec[k][3];
            step();
            obs  = {co_r, sum_r, co_l, sum_l, mismatch};
            want = {vec[k][2:0], vec[k][2:0], 1'b0};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL directed%0d got=%b want=%b", k, obs, want);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] obs, want;
        logic [2:0] e;
        for (int v = 0; v < 32; v++) begin
            if (v == 16) begin
                a = 2'b11; b = 2'b11; ci = 1'b1;
                rst = 1'b1;
                step();
                rst = 1'b0;
                obs = {co_r, sum_r, co_l, sum_l, mismatch};
                checks++;
                if (obs !== 7'b0) begin
                    failures++;
                    $display("FAIL mid_reset got=%b want=%b", obs, 7'b0);
                end
            end
            a  = v[1:0];
            b  = v[3:2];
            ci = v[4];
            e  = {1'b0, a} + {1'b0, b} + {2'b00, ci};
            step();
            obs  = {co_r, sum_r, co_l, sum_l, mismatch};
            want = {e, e, 1'b0};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL sweep a=%b b=%b ci=%b got=%b want=%b",
                         a, b, ci, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] obs;
        // Boundary pair on consecutive edges: max + max + 1, then 0 + 0 + 1.
        a = 2'b11; b = 2'b11; ci = 1'b1;
        step();
        a = 2'b00; b = 2'b00; ci = 1'b1;
        obs = {co_r, sum_r, co_l, sum_l, mismatch};
        checks++;
        if (obs !== 7'b111_111_0) begin
            failures++;
            $display("FAIL b2b_max got=%b want=%b", obs, 7'b1111110);
        end
        step();
        obs = {co_r, sum_r, co_l, sum_l, mismatch};
        checks++;
        if (obs !== 7'b001_001_0) begin
            failures++;
            $display("FAIL b2b_cin got=%b want=%b", obs, 7'b0010010);
        end
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; ci = 1'b0;
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
